// File: rtl/fetch_if.sv
// Instruction-memory channel: valid/ready request, in-order response without backpressure.
interface fetch_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic        resp_valid;
   logic [31:0] resp_data;

   modport master (
      output req_valid,
      output req_addr,
      input  req_ready,
      input  resp_valid,
      input  resp_data
   );

   modport slave (
      input  req_valid,
      input  req_addr,
      output req_ready,
      output resp_valid,
      output resp_data
   );
endinterface

// File: rtl/fetch.sv
// RV32I instruction-fetch stage: sequential imem requests, in-flight PC tracking,
// instruction buffer toward decode, redirect flush with discard of stale responses.
module fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        reset,
   fetch_if.master     imem,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   input  logic        id_ready,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] pc
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [31:0]   NOP     = 32'h0000_0013;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] drop_cnt;
   logic [CW-1:0] buf_wr;
   logic [CW-1:0] buf_rd;
   logic [AW-1:0] fl_wr;
   logic [AW-1:0] fl_rd;
   logic [31:0]   buf_pc   [DEPTH];
   logic [31:0]   buf_word [DEPTH];
   logic [31:0]   flight_pc[DEPTH];

   logic [CW-1:0] occupancy;
   logic [CW:0]   committed;
   logic          credit;
   logic          deq;
   logic          accept;
   logic          buf_push;
   logic          buf_pop;
   logic          unused_pc_low;

   assign unused_pc_low = &{1'b0, redirect_pc[1:0]};

   // Credit counts every word that will eventually occupy the buffer, stale ones included,
   // so the buffer can never be pushed while full.
   assign occupancy   = buf_wr - buf_rd;
   assign instr_valid = (occupancy != '0);
   assign deq         = instr_valid & id_ready;
   assign committed   = {1'b0, outstanding} + {1'b0, occupancy} - {{CW{1'b0}}, deq};
   assign credit      = (committed < {1'b0, DEPTH_C});

   assign imem.req_valid = credit & ~redirect & ~reset;
   assign imem.req_addr  = fetch_pc;
   assign accept         = imem.req_valid & imem.req_ready;
   assign buf_push       = imem.resp_valid & ~redirect & (drop_cnt == '0);
   assign buf_pop        = deq & ~redirect;

   assign instr = instr_valid ? buf_word[buf_rd[AW-1:0]] : NOP;
   assign pc    = instr_valid ? buf_pc[buf_rd[AW-1:0]]   : 32'h0000_0000;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fetch_pc    <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         buf_wr      <= '0;
         buf_rd      <= '0;
         fl_wr       <= '0;
         fl_rd       <= '0;
      end else begin
         if (accept)
            fl_wr <= fl_wr + AW'(1);
         if (imem.resp_valid)
            fl_rd <= fl_rd + AW'(1);
         outstanding <= outstanding + CW'(accept) - CW'(imem.resp_valid);

         // A redirect owns the cycle: everything still in flight becomes wrong-path.
         if (redirect) begin
            fetch_pc <= {redirect_pc[31:2], 2'b00};
            drop_cnt <= outstanding - CW'(imem.resp_valid);
            buf_wr   <= '0;
            buf_rd   <= '0;
         end else begin
            if (accept)
               fetch_pc <= fetch_pc + 32'd4;
            if (imem.resp_valid && drop_cnt != '0)
               drop_cnt <= drop_cnt - CW'(1);
            if (buf_push)
               buf_wr <= buf_wr + CW'(1);
            if (buf_pop)
               buf_rd <= buf_rd + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept)
         flight_pc[fl_wr] <= fetch_pc;
      if (buf_push) begin
         buf_pc[buf_wr[AW-1:0]]   <= flight_pc[fl_rd];
         buf_word[buf_wr[AW-1:0]] <= imem.resp_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         assert (!(buf_push && occupancy == DEPTH_C));
   end
endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the five-stage RV32I pipeline, directly upstream of the decode stage. Owns the fetch PC and issues sequential word requests to instruction memory over a valid/ready request channel with in-order responses. Buffers returned words with their PCs in a small FIFO that presents one instruction per cycle to decode. Accepts redirects from the branch-resolution stage and discards wrong-path words, including responses still in flight.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word-aligned)
- DEPTH, 4, instruction-buffer entries and maximum of outstanding plus buffered words (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- imem_req_valid  out  1  request to instruction memory
- imem_req_ready  in  1  memory accepts request this cycle
- imem_req_addr  out  32  word address of request (bits [1:0] always 0)
- imem_resp_valid  in  1  response word valid; in request order; no backpressure; ≥1 cycle after acceptance
- imem_resp_data  in  32  response instruction word
- redirect  in  1  flush and restart fetch at redirect_pc
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- id_ready  in  1  decode consumes head instruction this cycle
- instr_valid  out  1  buffer head holds a valid instruction
- instr  out  32  head instruction; 32'h0000_0013 (NOP) when instr_valid=0
- pc  out  32  PC of head instruction; 0 when instr_valid=0

## Operation
- State: fetch_pc (32), outstanding counter (0..DEPTH), drop counter (0..DEPTH), FIFO of DEPTH {pc, word} entries, FIFO of DEPTH in-flight PCs.
- Credit: issue permitted when outstanding + occupancy − (instr_valid & id_ready) < DEPTH.
- imem_req_valid = credit & !redirect & !reset; imem_req_addr = fetch_pc.
- Accepted request (valid & ready): push fetch_pc to in-flight FIFO, fetch_pc += 4 (wraps mod 2^32), outstanding += 1.
- Response: pop in-flight FIFO, outstanding −= 1. If drop counter > 0: discard word, drop −= 1. Else push {pc, word} into buffer.
- Dequeue: instr_valid & id_ready pops buffer head.
- Redirect (highest priority): buffer emptied; drop ← outstanding minus any response arriving this cycle (that response is discarded); fetch_pc ← {redirect_pc[31:2], 2'b00}; no request issued this cycle; dequeue this cycle is ignored (decode's instruction is wrong-path).
- Simultaneous accept, response, dequeue without redirect: all take effect; counters adjust by net amount.
- Buffer never overflows by construction of credit; overflow is an assertion failure.

## Timing
- Reset values: fetch_pc=RESET_PC, outstanding=0, drop=0, buffer empty; imem_req_valid=0, instr_valid=0, instr=NOP, pc=0, imem_req_addr=RESET_PC.
- Reset asserted mid-operation: all state cleared asynchronously; responses for pre-reset requests are the memory's responsibility to squash.
- First request in first cycle after reset deasserts.
- Latency: request accepted in cycle t, response in t+L, instr_valid in t+L+1 (response registered into buffer; no bypass).
- Throughput: one instruction per cycle sustained when DEPTH ≥ L+1 and id_ready=1.
- Redirect in cycle t: first new-path request in t+1; instr_valid=0 in t+1 until new-path word arrives.
- Second redirect while drop>0: drop recomputed from current outstanding; no stale word ever enters buffer.

## Test plan
- Reset, RESET_PC=0x100, memory L=1 always ready, id_ready=1 -> requests 0x100,0x104,0x108… one per cycle; instr_valid first high 2 cycles after first request, pc sequence 0x100,0x104…, no gaps.
- id_ready=0 for 10 cycles, DEPTH=4 -> at most 4 words outstanding+buffered, imem_req_valid drops to 0; on id_ready=1 instructions resume in order with no loss or duplicate.
- imem_req_ready toggling 1,0,0,1 -> imem_req_addr held stable while unaccepted; pc sequence remains contiguous.
- Memory L=3, three requests in flight, redirect to 0x2002 -> three stale responses discarded; next request 0x2000; first valid output pc=0x2000.
- Redirect in same cycle as a response and id_ready=1 -> response discarded, buffer empty next cycle, no request that cycle, fetch resumes at redirect target.
- fetch_pc=0xFFFF_FFFC -> next request address 0x0000_0000; reset asserted mid-stream -> instr_valid=0 and imem_req_valid=0 immediately.
